// File: rtl/tmr_resp_distributor.sv
// Return path of the TMR lockstep bus: fans the OBI response out to all harts,
// tracks outstanding transactions and runs the isolate/drain/resync recovery FSM.
package tmr_resp_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    DRAIN       = 2'd1,
    WAIT_RESYNC = 2'd2,
    HALT        = 2'd3
  } state_e;
endpackage

module tmr_resp_distributor
  import tmr_resp_pkg::*;
#(
  parameter int NHARTS          = 3,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  obi_req_t                     voted_req_i,
  output obi_req_t                     bus_req_o,
  input  obi_resp_t                    bus_resp_i,
  output obi_resp_t [NHARTS-1:0]       core_resp_o,
  input  logic                         error_i,
  input  logic [NHARTS-1:0]            error_id_i,
  output logic                         resync_req_o,
  input  logic                         resync_done_i,
  output logic [NHARTS-1:0]            hart_mask_o,
  output logic [CW-1:0]                outstanding_o,
  output logic [1:0]                   state_o,
  output logic                         unrecoverable_o,
  output logic                         proto_err_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  state_e             state_q, state_d;
  logic [NHARTS-1:0]  mask_q, mask_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               unrec_q, unrec_d;
  logic               proto_q, proto_d;
  logic [NHARTS-1:0]  rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;

  logic req_gate;
  logic inc;
  logic accept;

  // The request only reaches the bus in RUN, out of reset and with tracker room.
  assign req_gate = voted_req_i.req & rst_ni & (state_q == RUN) & (cnt_q < MAX_CNT);
  assign inc      = req_gate & bus_resp_i.gnt;
  assign accept   = bus_resp_i.rvalid & (cnt_q != '0);

  always_comb begin
    bus_req_o     = voted_req_i;
    bus_req_o.req = req_gate;
    core_resp_o   = '0;
    for (int i = 0; i < NHARTS; i++) begin
      core_resp_o[i].gnt    = bus_resp_i.gnt & req_gate & mask_q[i];
      core_resp_o[i].rvalid = rvalid_q[i];
      core_resp_o[i].rdata  = rdata_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    unrec_d  = unrec_q;
    proto_d  = proto_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;

    if (inc && !accept) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!inc && accept) begin
      cnt_d = cnt_q - CW'(1);
    end

    // A response arriving with nothing outstanding is dropped and flagged.
    if (bus_resp_i.rvalid && !accept) begin
      proto_d = 1'b1;
    end
    if (accept) begin
      rdata_d  = bus_resp_i.rdata;
      rvalid_d = mask_q;
    end

    unique case (state_q)
      RUN: begin
        if (enable_i && error_i) begin
          if ($onehot(error_id_i)) begin
            mask_d  = ~error_id_i;
            state_d = DRAIN;
          end else if (error_id_i != '0) begin
            unrec_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      DRAIN: begin
        // A second hart disagreeing while draining means majority is lost.
        if (enable_i && error_i && ((error_id_i & mask_q) != '0)) begin
          unrec_d = 1'b1;
          state_d = HALT;
        end else if (cnt_q == '0) begin
          state_d = WAIT_RESYNC;
        end
      end
      WAIT_RESYNC: begin
        if (resync_done_i) begin
          mask_d  = '1;
          state_d = RUN;
        end
      end
      HALT: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      mask_q   <= '1;
      cnt_q    <= '0;
      unrec_q  <= 1'b0;
      proto_q  <= 1'b0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      unrec_q  <= unrec_d;
      proto_q  <= proto_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign resync_req_o    = (state_q == WAIT_RESYNC);
  assign hart_mask_o     = mask_q;
  assign outstanding_o   = cnt_q;
  assign state_o         = state_q;
  assign unrecoverable_o = unrec_q;
  assign proto_err_o     = proto_q;

endmodule

// File: tb/tb_tmr_resp_distributor.sv
// Bench for tmr_resp_distributor: table-driven cycle vectors plus hand-written
// fault/resync sequences, with a scoreboard matching delivered responses.
module tb_tmr_resp_distributor;
  import tmr_resp_pkg::*;

  logic                 clk;
  logic                 rst_ni;
  logic                 enable_i;
  obi_req_t             voted_req_i;
  obi_req_t             bus_req_o;
  obi_resp_t            bus_resp_i;
  obi_resp_t [2:0]      core_resp_o;
  logic                 error_i;
  logic [2:0]           error_id_i;
  logic                 resync_req_o;
  logic                 resync_done_i;
  logic [2:0]           hart_mask_o;
  logic [1:0]           outstanding_o;
  logic [1:0]           state_o;
  logic                 unrecoverable_o;
  logic                 proto_err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        push;
    logic        exp_req;
    logic [2:0]  exp_gnt;
    logic [1:0]  exp_cnt;
    logic [2:0]  exp_rv;
    logic        exp_proto;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  mask;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[12];

  tmr_resp_distributor dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .enable_i        (enable_i),
    .voted_req_i     (voted_req_i),
    .bus_req_o       (bus_req_o),
    .bus_resp_i      (bus_resp_i),
    .core_resp_o     (core_resp_o),
    .error_i         (error_i),
    .error_id_i      (error_id_i),
    .resync_req_o    (resync_req_o),
    .resync_done_i   (resync_done_i),
    .hart_mask_o     (hart_mask_o),
    .outstanding_o   (outstanding_o),
    .state_o         (state_o),
    .unrecoverable_o (unrecoverable_o),
    .proto_err_o     (proto_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] gntVec();
    for (int i = 0; i < 3; i++) gntVec[i] = core_resp_o[i].gnt;
  endfunction

  function automatic logic [2:0] rvVec();
    for (int i = 0; i < 3; i++) rvVec[i] = core_resp_o[i].rvalid;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    voted_req_i    = '0;
    bus_resp_i     = '0;
    error_i        = 1'b0;
    error_id_i     = '0;
    resync_done_i  = 1'b0;
  endtask

  task automatic resetDut();
    step();
    rst_ni = 1'b0;
    clearInputs();
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    step();
    voted_req_i.req    = v.req;
    voted_req_i.addr   = v.addr;
    bus_resp_i.gnt     = v.gnt;
    bus_resp_i.rvalid  = v.rv;
    bus_resp_i.rdata   = v.rdata;
    if (v.push) sbq.push_back('{rdata: v.rdata, mask: 3'b111});
    @(negedge clk);
    checkOutput("bus_req", 32'(bus_req_o.req), 32'(v.exp_req));
    checkOutput("bus_addr", bus_req_o.addr, v.addr);
    checkOutput("core_gnt", 32'(gntVec()), 32'(v.exp_gnt));
    checkOutput("outstanding", 32'(outstanding_o), 32'(v.exp_cnt));
    checkOutput("core_rvalid", 32'(rvVec()), 32'(v.exp_rv));
    checkOutput("proto_err", 32'(proto_err_o), 32'(v.exp_proto));
  endtask

  // Every delivered response must match the oldest expected one, in data and hart set.
  always @(negedge clk) begin
    if (rvVec() != 3'b000) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_unexpected_rvalid", 32'(rvVec()), 32'h0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        checkOutput("sb_mask", 32'(rvVec()), 32'(e.mask));
        for (int i = 0; i < 3; i++)
          if (core_resp_o[i].rvalid) checkOutput("sb_rdata", core_resp_o[i].rdata, e.rdata);
      end
    end
  end

  initial begin
    //            req addr       gnt rv rdata         push ereq egnt    ecnt   erv     eproto
    vecs[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'b111, 2'd0, 3'b000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'b000, 2'd1, 3'b000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 3'b000, 2'd1, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'b000, 2'd0, 3'b111, 1'b0};
    vecs[4]  = '{1'b1, 32'h204, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'b111, 2'd0, 3'b000, 1'b0};
    vecs[5]  = '{1'b1, 32'h208, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'b111, 2'd1, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 32'h20C, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0, 3'b000, 2'd2, 3'b000, 1'b0};
    vecs[7]  = '{1'b1, 32'h20C, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 3'b111, 2'd1, 3'b111, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h33333333, 1'b1, 1'b0, 3'b000, 2'd1, 3'b111, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'b000, 2'd0, 3'b111, 1'b0};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b0};
    vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1};

    rst_ni   = 1'b0;
    enable_i = 1'b1;
    clearInputs();
    voted_req_i.req = 1'b1;
    bus_resp_i.gnt  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("reset_bus_req", 32'(bus_req_o.req), 32'h0);
    end
    step();
    rst_ni = 1'b1;
    clearInputs();
    @(negedge clk);
    checkOutput("reset_state", 32'(state_o), 32'h0);
    checkOutput("reset_outstanding", 32'(outstanding_o), 32'h0);
    checkOutput("reset_mask", 32'(hart_mask_o), 32'h7);
    checkOutput("reset_unrec", 32'(unrecoverable_o), 32'h0);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    checkOutput("rdata_hold", core_resp_o[0].rdata, 32'h33333333);

    // Single fault: isolate hart 1, drain, resync.
    resetDut();
    step();
    voted_req_i.req = 1'b1;
    bus_resp_i.gnt  = 1'b1;
    step();
    clearInputs();
    error_i    = 1'b1;
    error_id_i = 3'b010;
    @(negedge clk);
    checkOutput("sf_proto_cleared", 32'(proto_err_o), 32'h0);
    checkOutput("sf_cnt", 32'(outstanding_o), 32'h1);
    step();
    clearInputs();
    voted_req_i.req = 1'b1;
    @(negedge clk);
    checkOutput("sf_state_drain", 32'(state_o), 32'h1);
    checkOutput("sf_mask", 32'(hart_mask_o), 32'h5);
    checkOutput("sf_drain_gated", 32'(bus_req_o.req), 32'h0);
    step();
    clearInputs();
    bus_resp_i.rvalid = 1'b1;
    bus_resp_i.rdata  = 32'hCAFEF00D;
    sbq.push_back('{rdata: 32'hCAFEF00D, mask: 3'b101});
    step();
    clearInputs();
    @(negedge clk);
    checkOutput("sf_cnt_zero", 32'(outstanding_o), 32'h0);
    step();
    voted_req_i.req = 1'b1;
    @(negedge clk);
    checkOutput("sf_state_wait", 32'(state_o), 32'h2);
    checkOutput("sf_resync_req", 32'(resync_req_o), 32'h1);
    checkOutput("sf_wait_gated", 32'(bus_req_o.req), 32'h0);
    step();
    clearInputs();
    resync_done_i = 1'b1;
    step();
    resync_done_i = 1'b0;
    @(negedge clk);
    checkOutput("sf_state_run", 32'(state_o), 32'h0);
    checkOutput("sf_mask_restored", 32'(hart_mask_o), 32'h7);
    checkOutput("sf_resync_low", 32'(resync_req_o), 32'h0);

    // Double fault: halt until reset, resync_done ignored.
    step();
    error_i    = 1'b1;
    error_id_i = 3'b011;
    step();
    clearInputs();
    voted_req_i.req = 1'b1;
    @(negedge clk);
    checkOutput("df_state_halt", 32'(state_o), 32'h3);
    checkOutput("df_unrec", 32'(unrecoverable_o), 32'h1);
    checkOutput("df_gated", 32'(bus_req_o.req), 32'h0);
    step();
    resync_done_i = 1'b1;
    step();
    resync_done_i = 1'b0;
    step();
    @(negedge clk);
    checkOutput("df_halt_sticky", 32'(state_o), 32'h3);
    resetDut();
    voted_req_i.req = 1'b1;
    @(negedge clk);
    checkOutput("df_reset_state", 32'(state_o), 32'h0);
    checkOutput("df_reset_unrec", 32'(unrecoverable_o), 32'h0);
    checkOutput("df_reset_req", 32'(bus_req_o.req), 32'h1);

    // Errors ignored while fault handling is disabled.
    step();
    clearInputs();
    enable_i   = 1'b0;
    error_i    = 1'b1;
    error_id_i = 3'b001;
    step();
    clearInputs();
    @(negedge clk);
    checkOutput("dis_state", 32'(state_o), 32'h0);
    checkOutput("dis_mask", 32'(hart_mask_o), 32'h7);

    // Second hart faulting during drain escalates to halt.
    step();
    enable_i   = 1'b1;
    error_i    = 1'b1;
    error_id_i = 3'b100;
    step();
    error_id_i = 3'b001;
    step();
    clearInputs();
    @(negedge clk);
    checkOutput("drain_escalate_state", 32'(state_o), 32'h3);
    checkOutput("drain_escalate_unrec", 32'(unrecoverable_o), 32'h1);

    step();
    checkOutput("sb_empty", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
